// File: rtl/mips_dmem_responder.sv
// Word-organised data memory slave for the MIPS core: request/ready handshake with WAIT_STATES wait cycles.
// Define MIPS_DMEM_BYTE_EN to add the ByteEn[3:0] store byte-lane mask.
module mips_dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        MemReq,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
`ifdef MIPS_DMEM_BYTE_EN
    input  logic [3:0]  ByteEn,
`endif
    output logic [31:0] ReadData,
    output logic        MemReady,
    output logic        MemErr
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (WAIT_STATES < 2) ? 1 : $clog2(WAIT_STATES + 1);
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        rdata_q;
    logic               ready_q;
    logic               err_out_q;

    // request attributes captured on accept
    logic [IDX_W-1:0]   idx_q;
    logic               err_q;
    logic               wr_q;
    logic [3:0]         be_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rd_hold_q;

    logic [31:0]        offset;
    logic [IDX_W-1:0]   idx_d;
    logic               err_d;
    logic [3:0]         be_d;
    logic               accept;

    logic               commit;
    logic [IDX_W-1:0]   c_idx;
    logic               c_err;
    logic               c_wr;
    logic [3:0]         c_be;
    logic [31:0]        c_data;

    logic [31:0]        mem [DEPTH_WORDS];

    assign offset = Addr - BASE_ADDR;
    assign idx_d  = offset[IDX_W+1:2];
    assign err_d  = (Addr[1:0] != 2'b00) || ({1'b0, offset} >= LIMIT);
    assign accept = (state_q == S_IDLE) && MemReq;
`ifdef MIPS_DMEM_BYTE_EN
    assign be_d   = ByteEn;
`else
    assign be_d   = 4'hF;
`endif

    // The access commits on the edge entering RESP; with no wait states that is the accept edge itself.
    always_comb begin
        commit = 1'b0;
        c_idx  = idx_q;
        c_err  = err_q;
        c_wr   = wr_q;
        c_be   = be_q;
        c_data = wdata_q;
        if (WAIT_STATES == 0) begin
            commit = accept;
            c_idx  = idx_d;
            c_err  = err_d;
            c_wr   = MemWrite;
            c_be   = be_d;
            c_data = WriteData;
        end else begin
            commit = (state_q == S_WAIT) && (cnt_q == CNT_W'(1));
        end
    end

    always_ff @(posedge CLK) begin
        if (commit && c_wr && !c_err && !Reset) begin
            for (int b = 0; b < 4; b++) begin
                if (c_be[b]) mem[c_idx][8*b +: 8] <= c_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            idx_q   <= idx_d;
            err_q   <= err_d;
            wr_q    <= MemWrite;
            be_q    <= be_d;
            wdata_q <= WriteData;
        end
        if (commit) rd_hold_q <= (c_wr || c_err) ? 32'd0 : mem[c_idx];
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            err_out_q <= 1'b0;
        end else begin
            ready_q   <= 1'b0;
            err_out_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (MemReq) begin
                        cnt_q   <= CNT_W'(WAIT_STATES);
                        state_q <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) state_q <= S_RESP;
                end
                S_RESP: begin
                    state_q   <= S_IDLE;
                    ready_q   <= 1'b1;
                    err_out_q <= err_q;
                    rdata_q   <= rd_hold_q;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ReadData = rdata_q;
    assign MemReady = ready_q;
    assign MemErr   = err_out_q;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Bench for mips_dmem_responder: transaction-level model with per-cycle compare plus directed literal checks.
module tb_mips_dmem_responder;

    localparam int          WS    = 2;
    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        MemReq = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Addr = 32'd0;
    logic [31:0] WriteData = 32'd0;
`ifdef MIPS_DMEM_BYTE_EN
    logic [3:0]  ByteEn = 4'hF;
`endif
    logic [31:0] ReadData;
    logic        MemReady;
    logic        MemErr;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 CLK = ~CLK;

    mips_dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .WAIT_STATES(WS),
        .BASE_ADDR(BASE)
    ) dut (
        .CLK(CLK),
        .Reset(Reset),
        .MemReq(MemReq),
        .MemWrite(MemWrite),
        .Addr(Addr),
        .WriteData(WriteData),
`ifdef MIPS_DMEM_BYTE_EN
        .ByteEn(ByteEn),
`endif
        .ReadData(ReadData),
        .MemReady(MemReady),
        .MemErr(MemErr)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Transaction model: one request in flight, response WS+1 edges after accept, next accept one edge later.
    logic [31:0] mmem [DEPTH];
    int          edge_n = 0;
    int          free_e = 0;
    bit          p_act = 1'b0;
    bit          p_wr, p_err;
    int          p_idx, p_commit, p_resp;
    logic [31:0] p_data, p_rd, m_off;
    logic [3:0]  p_be;
    logic        exp_ready = 1'b0;
    logic        exp_err = 1'b0;
    logic [31:0] exp_rdata = 32'd0;

    initial forever begin
        @(posedge CLK or posedge Reset);
        if (Reset) begin
            p_act = 1'b0; exp_ready = 1'b0; exp_err = 1'b0; exp_rdata = 32'd0; free_e = 0;
        end else begin
            edge_n++;
            exp_ready = 1'b0;
            exp_err   = 1'b0;
            if (p_act && edge_n == p_resp) begin
                exp_ready = 1'b1;
                exp_err   = p_err;
                exp_rdata = (p_err || p_wr) ? 32'd0 : p_rd;
                p_act     = 1'b0;
                free_e    = edge_n + 1;
            end
            if (!p_act && edge_n >= free_e && MemReq) begin
                m_off    = Addr - BASE;
                p_err    = (Addr[1:0] != 2'b00) || (m_off >= 32'(DEPTH * 4));
                p_idx    = int'(m_off[7:2]);
                p_wr     = MemWrite;
                p_data   = WriteData;
`ifdef MIPS_DMEM_BYTE_EN
                p_be     = ByteEn;
`else
                p_be     = 4'hF;
`endif
                p_commit = edge_n + WS;
                p_resp   = p_commit + 1;
                p_act    = 1'b1;
            end
            if (p_act && edge_n == p_commit && !p_err) begin
                if (p_wr) begin
                    for (int b = 0; b < 4; b++)
                        if (p_be[b]) mmem[p_idx][8*b +: 8] = p_data[8*b +: 8];
                end else begin
                    p_rd = mmem[p_idx];
                end
            end
        end
    end

    initial forever begin
        @(negedge CLK);
        if (chk_en) begin
            chk("cyc_MemReady", {31'd0, MemReady}, {31'd0, exp_ready});
            chk("cyc_MemErr", {31'd0, MemErr}, {31'd0, exp_err});
            chk("cyc_ReadData", ReadData, exp_rdata);
        end
    end

    task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic er, output int lat);
        @(posedge CLK); #1;
        MemReq = 1'b1; MemWrite = wr; Addr = a; WriteData = d;
`ifdef MIPS_DMEM_BYTE_EN
        ByteEn = 4'hF;
`endif
        @(posedge CLK);
        lat = -1; rd = 32'd0; er = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge CLK); #1;
            if (MemReady) begin
                lat = n; rd = ReadData; er = MemErr;
                break;
            end
        end
        MemReq = 1'b0;
        if (lat < 0) begin
            checks++; errors++;
            $display("FAIL timeout: no MemReady within 20 edges for addr %h", a);
        end
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          nresp;
    int          resp_at [3];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_ReadData", ReadData, 32'd0);
        chk("rst_MemReady", {31'd0, MemReady}, 32'd0);
        chk("rst_MemErr", {31'd0, MemErr}, 32'd0);
        #2 Reset = 1'b0;
        chk_en = 1'b1;

        // preload words used later
        do_req(1'b1, 32'h0, 32'hA0A0_0000, rd, er, lat);
        do_req(1'b1, 32'h4, 32'hA1A1_1111, rd, er, lat);
        do_req(1'b1, 32'hFC, 32'hCAFE_F00D, rd, er, lat);
        do_req(1'b1, 32'h20, 32'hAAAA_5555, rd, er, lat);

        // store then load at 0x10
        do_req(1'b1, 32'h10, 32'hDEAD_BEEF, rd, er, lat);
        chk("t1_st_latency", 32'(lat), 32'd3);
        chk("t1_st_err", {31'd0, er}, 32'd0);
        chk("t1_st_rdata", rd, 32'd0);
        do_req(1'b0, 32'h10, 32'h0, rd, er, lat);
        chk("t1_ld_latency", 32'(lat), 32'd3);
        chk("t1_ld_err", {31'd0, er}, 32'd0);
        chk("t1_ld_rdata", rd, 32'hDEAD_BEEF);
        repeat (3) @(posedge CLK);
        #1 chk("t1_hold", ReadData, 32'hDEAD_BEEF);

        // misaligned load
        do_req(1'b0, 32'h12, 32'h0, rd, er, lat);
        chk("t2_err", {31'd0, er}, 32'd1);
        chk("t2_rdata", rd, 32'd0);
        chk("t2_latency", 32'(lat), 32'd3);
        do_req(1'b0, 32'h10, 32'h0, rd, er, lat);
        chk("t2_word_kept", rd, 32'hDEAD_BEEF);

        // out-of-range store, last valid word, wrapped address
        do_req(1'b1, 32'h100, 32'h1, rd, er, lat);
        chk("t3_oor_err", {31'd0, er}, 32'd1);
        do_req(1'b0, 32'hFC, 32'h0, rd, er, lat);
        chk("t3_last_err", {31'd0, er}, 32'd0);
        chk("t3_last_rdata", rd, 32'hCAFE_F00D);
        do_req(1'b0, 32'hFFFF_FFFC, 32'h0, rd, er, lat);
        chk("t3_wrap_err", {31'd0, er}, 32'd1);
        do_req(1'b0, 32'hFC, 32'h0, rd, er, lat);
        chk("t3_ld_back", rd, 32'hCAFE_F00D);

        // reset during WAIT aborts the store
        @(posedge CLK); #1;
        MemReq = 1'b1; MemWrite = 1'b1; Addr = 32'h20; WriteData = 32'h1234_5678;
        @(posedge CLK);
        @(posedge CLK); #1;
        Reset = 1'b1; MemReq = 1'b0;
        #1;
        chk("t4_rst_ReadData", ReadData, 32'd0);
        chk("t4_rst_MemReady", {31'd0, MemReady}, 32'd0);
        chk("t4_rst_MemErr", {31'd0, MemErr}, 32'd0);
        @(posedge CLK);
        @(posedge CLK); #3;
        Reset = 1'b0;
        do_req(1'b0, 32'h20, 32'h0, rd, er, lat);
        chk("t4_aborted", rd, 32'hAAAA_5555);

        // MemReq held 12 cycles with alternating address
        @(posedge CLK); #1;
        MemReq = 1'b1; MemWrite = 1'b0; Addr = 32'h0;
        nresp = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK); #1;
            if (MemReady) begin
                if (nresp < 3) resp_at[nresp] = i;
                nresp++;
                chk("t5_rdata", ReadData, 32'hA0A0_0000);
            end
            Addr = ((i + 1) % 2 == 1) ? 32'h4 : 32'h0;
        end
        MemReq = 1'b0;
        chk("t5_count", 32'(nresp), 32'd3);
        if (nresp == 3) begin
            chk("t5_first", 32'(resp_at[0]), 32'd3);
            chk("t5_gap1", 32'(resp_at[1] - resp_at[0]), 32'd4);
            chk("t5_gap2", 32'(resp_at[2] - resp_at[1]), 32'd4);
        end
        repeat (6) @(posedge CLK);

`ifdef MIPS_DMEM_BYTE_EN
        do_req(1'b1, 32'h8, 32'h1122_3344, rd, er, lat);
        @(posedge CLK); #1;
        MemReq = 1'b1; MemWrite = 1'b1; Addr = 32'h8; WriteData = 32'hAABB_CCDD; ByteEn = 4'b0101;
        @(posedge CLK);
        repeat (3) @(posedge CLK);
        #1 chk("t6_st_ready", {31'd0, MemReady}, 32'd1);
        MemReq = 1'b0;
        do_req(1'b0, 32'h8, 32'h0, rd, er, lat);
        chk("t6_merge", rd, 32'h11BB_33DD);
        @(posedge CLK); #1;
        MemReq = 1'b1; MemWrite = 1'b1; Addr = 32'h8; WriteData = 32'hFFFF_FFFF; ByteEn = 4'b0000;
        @(posedge CLK);
        repeat (3) @(posedge CLK);
        #1 chk("t6_be0_err", {31'd0, MemErr}, 32'd0);
        MemReq = 1'b0;
        do_req(1'b0, 32'h8, 32'h0, rd, er, lat);
        chk("t6_be0_nochange", rd, 32'h11BB_33DD);
`endif

        repeat (2) @(posedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
